// File: rtl/text_feeder_if.sv
// Character bus between the host-side writer and the text feeder.
// The master side writes characters and supplies init_done; the slave side
// (text_feeder) returns the paced character stream and FIFO status.
interface text_feeder_if #(
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [6:0]    wr_data;
  logic          init_done;
  logic [6:0]    data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output wr_en, wr_data, init_done,
    input  data_out, data_valid, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, init_done,
    output data_out, data_valid, full, empty, count, overflow
  );
endinterface

// File: rtl/text_feeder.sv
// Paced 7-bit character source ahead of the RC4 encryptor.
// Characters are buffered in a small FIFO and released as single-cycle
// data_valid pulses, at least GAP idle cycles apart, once init_done is seen.
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_INIT | encryptor not ready; no pops until init_done is sampled high
// IDLE      | ready; pops the head character whenever the FIFO is non-empty
// GAP_WAIT  | enforcing the minimum spacing after a pop; init_done ignored
module text_feeder #(
  parameter int DEPTH = 16,
  parameter int GAP   = 4
) (
  input  logic           clk,
  input  logic           reset,
  text_feeder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    IDLE      = 2'd1,
    GAP_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [6:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          overflow_q, overflow_d;
  logic [6:0]    mem_q [DEPTH];

  logic          full_w;
  logic          empty_w;
  logic          wr_acc;
  logic          pop;

  // Full/empty come only from the registered count, so a same-edge pop never
  // frees space for a write and a fresh write is never popped on its own edge.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign wr_acc  = bus.wr_en && !full_w;

  // Pacing FSM: next state, pop decision and output register loads.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      WAIT_INIT: begin
        if (bus.init_done) state_d = IDLE;
      end
      IDLE: begin
        if (!bus.init_done) begin
          state_d = WAIT_INIT;
        end else if (!empty_w) begin
          pop          = 1'b1;
          data_out_d   = mem_q[rd_ptr_q];
          data_valid_d = 1'b1;
          gap_cnt_d    = GW'(GAP);
          state_d      = GAP_WAIT;
        end
      end
      GAP_WAIT: begin
        gap_cnt_d = gap_cnt_q - GW'(1);
        if (gap_cnt_q == GW'(1)) state_d = IDLE;
      end
      default: begin
        state_d   = WAIT_INIT;
        gap_cnt_d = '0;
      end
    endcase
  end

  // FIFO bookkeeping: pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
    if (bus.wr_en && full_w) overflow_d = 1'b1;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State and control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_INIT;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      gap_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      gap_cnt_q    <= gap_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Character storage; not reset, stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
endmodule
